// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS write-back trace checker.
//   - Default widths/sizes used by mips_trace_checker and trace_ram.
//   - Checker FSM state encoding.
package mips_tb_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned DEPTH_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/trace_ram.sv
// Expected-trace storage: DEPTH entries of {register index, write-back data}.
// Ports:
//   i_clk            clock, write on rising edge
//   i_we             write enable
//   i_waddr          write index
//   i_wreg, i_wdata  entry contents to write
//   i_raddr          read index (asynchronous read)
//   o_rreg, o_rdata  entry contents at i_raddr
// Contents are deliberately not reset so a loaded table survives a checker reset.
module trace_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [REG_AW-1:0]        i_wreg,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [REG_AW-1:0]        o_rreg,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [REG_AW+DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_wreg, i_wdata};
        end
    end

    assign {o_rreg, o_rdata} = r_mem[i_raddr];

endmodule

// File: rtl/mips_trace_checker.sv
// Compares a processor's register write-back stream against a preloaded
// expected trace and reports pass, mismatch or timeout.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   exp_wr_en/idx/reg/data            load one expected entry (ignored in RUN)
//   exp_count                         number of valid entries, sampled on start
//   start                             arm the check (ignored in RUN)
//   wb_valid/reg/data                 observed write-back stream
//   busy, done, pass, timeout         registered status
//   err_index, err_reg, err_data      first failing entry and observed write-back
//   match_count, cycle_count          matched entries and elapsed RUN cycles
module mips_trace_checker
    import mips_tb_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exp_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   exp_wr_idx,
    input  logic [REG_AW-1:0]          exp_wr_reg,
    input  logic [DATA_W-1:0]          exp_wr_data,
    input  logic [$clog2(DEPTH):0]     exp_count,
    input  logic                       start,
    input  logic                       wb_valid,
    input  logic [REG_AW-1:0]          wb_reg,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [$clog2(DEPTH)-1:0]   err_index,
    output logic [REG_AW-1:0]          err_reg,
    output logic [DATA_W-1:0]          err_data,
    output logic [$clog2(DEPTH):0]     match_count,
    output logic [$clog2(TIMEOUT):0]   cycle_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned CYC_W = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CYC_W-1:0] TIMEOUT_C  = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] TIMEOUT_M1 = CYC_W'(TIMEOUT - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_exp_count;

    logic               w_ram_we;
    logic [REG_AW-1:0]  w_rd_reg;
    logic [DATA_W-1:0]  w_rd_data;
    logic [CNT_W-1:0]   w_count_clamped;
    logic               w_wb_live;
    logic               w_match;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_match_next;
    logic               w_complete;
    logic               w_at_limit;

    // The table is frozen while a check is running.
    assign w_ram_we = exp_wr_en && (r_state != RUN);

    trace_ram #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW),
        .DATA_W (DATA_W)
    ) u_trace_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_waddr (exp_wr_idx),
        .i_wreg  (exp_wr_reg),
        .i_wdata (exp_wr_data),
        .i_raddr (match_count[IDX_W-1:0]),
        .o_rreg  (w_rd_reg),
        .o_rdata (w_rd_data)
    );

    assign w_count_clamped = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;

    // Writes to $0 never reach the register file, so they are not trace events.
    assign w_wb_live    = wb_valid && (wb_reg != '0);
    assign w_match      = w_wb_live && (wb_reg == w_rd_reg) && (wb_data == w_rd_data);
    assign w_mismatch   = w_wb_live && !w_match;
    assign w_match_next = match_count + 1'b1;
    assign w_complete   = w_match && (w_match_next == r_exp_count);
    assign w_at_limit   = (cycle_count == TIMEOUT_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_exp_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            err_index   <= '0;
            err_reg     <= '0;
            err_data    <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end else begin
            case (r_state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        r_exp_count <= w_count_clamped;
                        match_count <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        err_index   <= '0;
                        err_reg     <= '0;
                        err_data    <= '0;
                        if (w_count_clamped == '0) begin
                            r_state <= PASS;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            pass    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cycle_count <= (cycle_count == TIMEOUT_C) ? cycle_count
                                                              : cycle_count + 1'b1;
                    if (w_match) begin
                        match_count <= w_match_next;
                    end
                    // Priority: completing match, then mismatch, then timeout.
                    if (w_complete) begin
                        r_state <= PASS;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                    end else if (w_mismatch) begin
                        r_state   <= FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err_index <= match_count[IDX_W-1:0];
                        err_reg   <= wb_reg;
                        err_data  <= wb_data;
                    end else if (w_at_limit) begin
                        r_state <= FAIL;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_trace_checker.sv
module tb_mips_trace_checker;

    localparam int DEPTH = 16;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_wr_en;
    logic [3:0]  exp_wr_idx;
    logic [4:0]  exp_wr_reg;
    logic [31:0] exp_wr_data;
    logic [4:0]  exp_count;
    logic        start;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy, done, pass, timeout;
    logic [3:0]  err_index;
    logic [4:0]  err_reg;
    logic [31:0] err_data;
    logic [4:0]  match_count;
    logic [4:0]  cycle_count;

    mips_trace_checker #(
        .DATA_W  (32),
        .REG_AW  (5),
        .DEPTH   (DEPTH),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exp_wr_en   (exp_wr_en),
        .exp_wr_idx  (exp_wr_idx),
        .exp_wr_reg  (exp_wr_reg),
        .exp_wr_data (exp_wr_data),
        .exp_count   (exp_count),
        .start       (start),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .err_index   (err_index),
        .err_reg     (err_reg),
        .err_data    (err_data),
        .match_count (match_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference: expected table and per-cycle write-back stimulus.
    logic [4:0]  m_reg  [DEPTH];
    logic [31:0] m_data [DEPTH];
    logic        s_v [TO];
    logic [4:0]  s_r [TO];
    logic [31:0] s_d [TO];

    // Model results: kind 0=pass 1=mismatch 2=timeout; e_end = deciding RUN cycle.
    int          e_kind, e_end, e_eidx;
    logic [4:0]  e_ereg;
    logic [31:0] e_edata;
    int          e_mc [TO];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exp_wr_en = 1'b0; exp_wr_idx = '0; exp_wr_reg = '0; exp_wr_data = '0;
        start = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    endtask

    task automatic load(input int idx, input logic [4:0] r, input logic [31:0] d);
        exp_wr_en = 1'b1; exp_wr_idx = 4'(idx); exp_wr_reg = r; exp_wr_data = d;
        step();
        exp_wr_en = 1'b0;
        m_reg[idx]  = r;
        m_data[idx] = d;
    endtask

    task automatic clear_stim();
        for (int t = 0; t < TO; t++) begin
            s_v[t] = 1'b0; s_r[t] = '0; s_d[t] = '0;
        end
    endtask

    task automatic put(input int t, input logic [4:0] r, input logic [31:0] d);
        s_v[t] = 1'b1; s_r[t] = r; s_d[t] = d;
    endtask

    task automatic load_base_table();
        load(0, 5'd1, 32'd5);
        load(1, 5'd2, 32'd3);
        load(2, 5'd3, 32'd8);
        load(3, 5'd2, 32'd12);
        load(4, 5'd3, 32'd5);
    endtask

    task automatic base_stream();
        clear_stim();
        for (int k = 0; k < 5; k++) put(k, m_reg[k], m_data[k]);
    endtask

    // Walk the stimulus through the trace rules: ignore $0, match in order,
    // stop at first mismatch or completion, give up after TO RUN cycles.
    task automatic model_run(input int n);
        int m;
        bit fin;
        m = 0; fin = (n == 0);
        e_kind = 0; e_end = -1; e_eidx = 0; e_ereg = '0; e_edata = '0;
        for (int t = 0; t < TO; t++) begin
            if (!fin) begin
                if (s_v[t] && s_r[t] != 5'd0) begin
                    if (s_r[t] == m_reg[m] && s_d[t] == m_data[m]) begin
                        m++;
                        if (m == n) begin fin = 1; e_kind = 0; e_end = t; end
                    end else begin
                        fin = 1; e_kind = 1; e_end = t;
                        e_eidx = m; e_ereg = s_r[t]; e_edata = s_d[t];
                    end
                end
                if (!fin && t == TO - 1) begin fin = 1; e_kind = 2; e_end = t; end
            end
            e_mc[t] = m;
        end
    endtask

    // Start a check, play the stimulus, verify per-cycle status and final result.
    // With noise set, junk table writes and stray starts are injected while running.
    task automatic run_trace(input int cnt, input bit noise, input string tag);
        int n;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        model_run(n);
        start = 1'b1; exp_count = 5'(cnt);
        step();
        start = 1'b0;
        check({tag, ":busy0"}, busy, n != 0);
        check({tag, ":done0"}, done, n == 0);
        for (int t = 0; t < TO + 2; t++) begin
            if (t < TO) begin
                wb_valid = s_v[t]; wb_reg = s_r[t]; wb_data = s_d[t];
            end else begin
                wb_valid = 1'b1; wb_reg = 5'($urandom_range(0, 31)); wb_data = $urandom();
            end
            if (noise && t <= e_end && $urandom_range(0, 2) == 0) begin
                exp_wr_en = 1'b1; exp_wr_idx = 4'($urandom_range(0, 15));
                exp_wr_reg = 5'($urandom_range(1, 31)); exp_wr_data = $urandom();
            end
            if (noise && t <= e_end && $urandom_range(0, 5) == 0) begin
                start = 1'b1; exp_count = 5'd0;
            end
            step();
            idle_inputs();
            if (t < TO) begin
                check({tag, ":busy"}, busy, t < e_end);
                check({tag, ":done"}, done, t >= e_end);
                check({tag, ":mcnt"}, match_count, e_mc[t]);
                check({tag, ":ccnt"}, cycle_count, (t < e_end) ? t + 1 : e_end + 1);
            end
        end
        check({tag, ":pass"}, pass, e_kind == 0);
        check({tag, ":done_f"}, done, 1);
        check({tag, ":busy_f"}, busy, 0);
        check({tag, ":timeout"}, timeout, e_kind == 2);
        check({tag, ":err_index"}, err_index, e_eidx);
        check({tag, ":err_reg"}, err_reg, e_ereg);
        check({tag, ":err_data"}, err_data, e_edata);
        check({tag, ":mcnt_f"}, match_count, e_mc[TO-1]);
        check({tag, ":ccnt_f"}, cycle_count, e_end + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":pass"}, pass, 0);
        check({tag, ":timeout"}, timeout, 0);
        check({tag, ":err_index"}, err_index, 0);
        check({tag, ":err_reg"}, err_reg, 0);
        check({tag, ":err_data"}, err_data, 0);
        check({tag, ":mcnt"}, match_count, 0);
        check({tag, ":ccnt"}, cycle_count, 0);
    endtask

    initial begin
        idle_inputs();
        exp_count = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Basic pass, then single mismatch at entry 2.
        load_base_table();
        base_stream();
        run_trace(5, 1'b0, "pass5");
        base_stream();
        put(2, 5'd3, 32'd7);
        run_trace(5, 1'b0, "mismatch");

        // No write-backs at all: timeout after TO cycles.
        clear_stim();
        run_trace(5, 1'b0, "timeout");

        // $0 writes interleaved with the expected stream.
        clear_stim();
        for (int k = 0; k < 5; k++) begin
            put(2 * k, 5'd0, 32'd99);
            put(2 * k + 1, m_reg[k], m_data[k]);
        end
        run_trace(5, 1'b0, "zero_reg");

        // Final match lands on the last allowed cycle.
        clear_stim();
        for (int k = 0; k < 4; k++) put(k, m_reg[k], m_data[k]);
        for (int t = 4; t < 15; t++) put(t, 5'd0, 32'd99);
        put(15, m_reg[4], m_data[4]);
        run_trace(5, 1'b0, "late_pass");

        // Reset mid-run after two matches; table must survive.
        base_stream();
        start = 1'b1; exp_count = 5'd5;
        step();
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wb_valid = 1'b1; wb_reg = s_r[t]; wb_data = s_d[t];
            step();
        end
        idle_inputs();
        check("midrun:mcnt", match_count, 2);
        check("midrun:busy", busy, 1);
        wb_valid = 1'b1; wb_reg = s_r[2]; wb_data = s_d[2];
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        check_all_zero("midrst");
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'd5;
        step();
        idle_inputs();
        check_all_zero("idle_wb");
        run_trace(5, 1'b0, "after_rst");

        // Empty trace passes immediately; noisy run checks table write lockout.
        clear_stim();
        run_trace(0, 1'b0, "empty");
        base_stream();
        run_trace(5, 1'b1, "wr_in_run");
        base_stream();
        run_trace(5, 1'b0, "table_kept");

        // exp_count above DEPTH clamps to a full 16-entry table.
        clear_stim();
        for (int k = 0; k < DEPTH; k++) begin
            load(k, 5'($urandom_range(1, 31)), $urandom());
            put(k, m_reg[k], m_data[k]);
        end
        run_trace(20, 1'b1, "clamp");

        // Randomized traces with gaps, $0 writes and occasional corruption.
        for (int it = 0; it < 24; it++) begin
            int n, t;
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) load(k, 5'($urandom_range(1, 31)), $urandom());
            clear_stim();
            t = 0;
            for (int k = 0; k < n && t < TO; k++) begin
                while (t < TO && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) put(t, 5'd0, $urandom());
                    t++;
                end
                if (t < TO) begin
                    case ($urandom_range(0, 11))
                        0: put(t, m_reg[k], m_data[k] ^ (32'd1 << $urandom_range(0, 31)));
                        1: put(t, 5'((m_reg[k] % 31) + 1), m_data[k]);
                        default: put(t, m_reg[k], m_data[k]);
                    endcase
                    t++;
                end
            end
            run_trace(($urandom_range(0, 3) == 0) ? n + 8 : n, 1'b1, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=stalled expected=finished");
        $fatal(1);
    end

endmodule
